// File: rtl/distribution_pingpong_ram_if.sv
// Bus bundle for the double-buffered distribution store: read port, masked
// write port, bank swap and fill-engine control/status.
interface distribution_pingpong_ram_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int Q             = 9,
    parameter int WORD_WIDTH    = 32,
    parameter int DATA_WIDTH    = Q * WORD_WIDTH
);
    logic                         rd_en;
    logic [ADDRESS_WIDTH-1:0]     rd_addr;
    logic signed [DATA_WIDTH-1:0] rd_data;
    logic                         rd_valid;
    logic                         wr_en;
    logic [ADDRESS_WIDTH-1:0]     wr_addr;
    logic [Q-1:0]                 wr_mask;
    logic signed [DATA_WIDTH-1:0] wr_data;
    logic                         swap;
    logic                         bank_sel;
    logic                         fill_start;
    logic signed [DATA_WIDTH-1:0] fill_data;
    logic                         busy;
    logic                         fill_done;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_mask, wr_data,
               swap, fill_start, fill_data,
        input  rd_data, rd_valid, bank_sel, busy, fill_done
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_mask, wr_data,
               swap, fill_start, fill_data,
        output rd_data, rd_valid, bank_sel, busy, fill_done
    );
endinterface

// File: rtl/distribution_pingpong_ram.sv
// Double-buffered lattice distribution store. One bank is read (current
// time-step), the other written (next time-step); swap exchanges them.
// Writes carry a per-direction mask; a fill engine stamps a pattern into
// every site of the write bank, one site per cycle.
module distribution_pingpong_ram #(
    parameter int NX            = 16,
    parameter int NY            = 16,
    parameter int DEPTH         = NX * NY,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int Q             = 9,
    parameter int WORD_WIDTH    = 32,
    parameter int DATA_WIDTH    = Q * WORD_WIDTH
) (
    input logic                        Clk,
    input logic                        Reset,
    distribution_pingpong_ram_if.slave bus
);
    typedef enum logic {
        IDLE,
        FILL
    } fill_state_t;

    localparam logic [ADDRESS_WIDTH:0]   DEPTH_LIMIT = (ADDRESS_WIDTH + 1)'(DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_SITE   = ADDRESS_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [2][DEPTH];

    fill_state_t              state;
    logic [ADDRESS_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0]    pattern;
    logic                     bank_sel_q;
    logic                     busy_q;
    logic                     fill_done_q;
    logic [DATA_WIDTH-1:0]    rd_data_q;
    logic                     rd_valid_q;

    logic rd_in_range;
    logic wr_in_range;
    logic wr_bank;

    assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_LIMIT);
    assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_LIMIT);
    assign wr_bank     = ~bank_sel_q;

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.bank_sel  = bank_sel_q;
    assign bus.busy      = busy_q;
    assign bus.fill_done = fill_done_q;

    // Fill FSM plus bank selection; swaps are only honoured while idle so the
    // fill target bank cannot change under it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            pattern     <= '0;
            bank_sel_q  <= 1'b0;
            busy_q      <= 1'b0;
            fill_done_q <= 1'b0;
        end else begin
            fill_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.swap) begin
                        bank_sel_q <= ~bank_sel_q;
                    end
                    if (bus.fill_start) begin
                        state   <= FILL;
                        busy_q  <= 1'b1;
                        cnt     <= '0;
                        pattern <= bus.fill_data;
                    end
                end
                FILL: begin
                    if (cnt == LAST_SITE) begin
                        state       <= IDLE;
                        busy_q      <= 1'b0;
                        fill_done_q <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write-bank update: the fill engine owns the port while active,
    // otherwise external writes land direction by direction under the mask.
    always_ff @(posedge Clk) begin
        if (state == FILL) begin
            mem[wr_bank][cnt] <= pattern;
        end else if (bus.wr_en && wr_in_range) begin
            for (int unsigned k = 0; k < Q; k++) begin
                if (bus.wr_mask[k]) begin
                    mem[wr_bank][bus.wr_addr][k*WORD_WIDTH +: WORD_WIDTH] <=
                        bus.wr_data[k*WORD_WIDTH +: WORD_WIDTH];
                end
            end
        end
    end

    // Registered read from the read bank; out-of-range sites read as zero.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_data_q <= rd_in_range ? mem[bank_sel_q][bus.rd_addr] : '0;
            end
        end
    end
endmodule

// File: doc/distribution_pingpong_ram.md
Name: distribution_pingpong_ram

Overview:
- Double-buffered lattice distribution store for the LBM core. Holds Q directional distributions per lattice site.
- Two banks. One bank is the read (current time-step) bank; the other is the write (next time-step) bank. A swap command exchanges their roles at a time-step boundary.
- Per-direction write mask lets the streaming stage scatter individual directions to neighbour addresses.
- Built-in fill engine initialises the whole write bank to an equilibrium pattern.

Parameters:
- NX, 16, lattice width in sites.
- NY, 16, lattice height in sites.
- DEPTH, NX*NY, sites per bank.
- ADDRESS_WIDTH, $clog2(DEPTH), site address width.
- Q, 9, distributions per site (D2Q9).
- WORD_WIDTH, 32, signed width of one distribution.
- DATA_WIDTH, Q*WORD_WIDTH, full site word width. Direction k occupies bits [k*WORD_WIDTH +: WORD_WIDTH].

Ports:
- Clk  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- rd_en  input  1  read request to the read bank.
- rd_addr  input  ADDRESS_WIDTH  read site address.
- rd_data  output  DATA_WIDTH  registered read data (signed).
- rd_valid  output  1  high the cycle rd_data is valid.
- wr_en  input  1  write request to the write bank.
- wr_addr  input  ADDRESS_WIDTH  write site address.
- wr_mask  input  Q  per-direction write enable; bit k enables direction k.
- wr_data  input  DATA_WIDTH  write data (signed).
- swap  input  1  single-cycle request to exchange banks.
- bank_sel  output  1  index of the current read bank; the write bank is ~bank_sel.
- fill_start  input  1  start filling the write bank.
- fill_data  input  DATA_WIDTH  pattern written to every site during a fill; sampled at fill_start.
- busy  output  1  high while a fill is in progress.
- fill_done  output  1  one-cycle pulse when a fill completes.

Behaviour:
- Reset (asynchronous): rd_data=0, rd_valid=0, bank_sel=0, busy=0, fill_done=0, FSM goes to IDLE. Memory contents are not cleared and are undefined after reset.
- Reset asserted mid-fill aborts the fill. No fill_done pulse is produced.
- Read latency is 1 cycle:
  - rd_en at edge N gives rd_data = bank[bank_sel][rd_addr] and rd_valid=1 after edge N.
  - rd_valid=0 on cycles with no rd_en. rd_data holds its last value.
  - Reads are allowed during a fill; they always target the read bank.
- Write: wr_en at an edge updates only the directions k with wr_mask[k]=1 at bank[~bank_sel][wr_addr]. Directions with mask bit 0 keep their old value. wr_mask=0 writes nothing.
- Out of range (address >= DEPTH):
  - Out-of-range write is ignored.
  - Out-of-range read returns rd_data=0 with rd_valid=1.
- Reads and writes always target opposite banks, so an equal rd_addr and wr_addr is not a hazard.
- Swap:
  - When swap=1 and busy=0, bank_sel toggles at that edge.
  - A read or write issued in the same cycle as swap uses the pre-swap banks.
  - A read issued the next cycle sees the newly written bank.
  - swap while busy=1 is ignored; the request is dropped, not queued.
- Fill FSM states: IDLE, FILL.
  - IDLE -> FILL on fill_start while busy=0. At that edge fill_data is latched, the counter is cleared to 0, and busy is set to 1.
  - In FILL, one site per cycle is written: bank[~bank_sel][cnt] = latched pattern, all Q directions. cnt then increments.
  - When the write to address DEPTH-1 occurs: FILL -> IDLE, busy=0, and fill_done=1 for exactly the following cycle.
  - A fill takes DEPTH cycles.
  - fill_start while busy is ignored.
  - External wr_en while busy is ignored; the fill has priority.
- bank_sel is frozen during a fill, so the fill always lands in the bank that was the write bank at fill_start.
- Widths: data is stored bit-exact. No arithmetic or saturation is performed.

Test Plan:
- Reset then read/write:
  - Reset pulse gives rd_data=0, bank_sel=0.
  - Write addr 0x12, mask 9'h1FF, data {9{32'sd5}}. Swap, then read 0x12.
  - Required: rd_data={9{32'sd5}} with rd_valid one cycle after rd_en.
- Masked write:
  - Fill pattern {9{32'sd1}}, then write addr 0x03 with mask 9'b000000101 and data {9{-32'sd7}}. Swap, then read 0x03.
  - Required: directions 0 and 2 = -7; all others = 1.
- Bank isolation:
  - Write addr 0x00 = 6 while reading addr 0x00 in the same cycle.
  - Required: the read returns the old read-bank value. After swap, the read returns 6.
- Fill:
  - fill_start with pattern {9{32'sd3}}.
  - Required: busy=1 for 256 cycles; fill_done pulses once; swap issued during busy is ignored (bank_sel unchanged); after swap, reads of 0x00, 0x7F and 0xFF each return 3.
- Swap/access collision:
  - Assert swap, rd_en and wr_en in the same cycle.
  - Required: the read returns old read-bank data, the write lands in the old write bank, and bank_sel toggles.
- Reset mid-fill:
  - Assert Reset at fill cycle 100.
  - Required: busy=0 immediately (asynchronous), no fill_done, bank_sel=0. A new fill_start is then accepted.
